// File: rtl/exe_muldiv.sv
// Execute stage: single-cycle OP/OP-IMM ALU plus an optional iterative
// M-extension unit (shift-add multiplier, restoring divider) with registered results.
module exe_muldiv #(
  parameter int XLEN        = 32,
  parameter int RADDR_WIDTH = 5,
  parameter int MULDIV_EN   = 1
) (
  input  logic                   clk_i,
  input  logic                   rst_n_i,
  input  logic                   valid_i,
  output logic                   ready_o,
  input  logic                   flush_i,
  input  logic [31:0]            inst_i,
  input  logic [XLEN-1:0]        op1_i,
  input  logic [XLEN-1:0]        op2_i,
  input  logic                   reg_we_i,
  input  logic [RADDR_WIDTH-1:0] reg_waddr_i,
  output logic                   valid_o,
  output logic                   reg_we_o,
  output logic [RADDR_WIDTH-1:0] reg_waddr_o,
  output logic [XLEN-1:0]        reg_wdata_o
);
  localparam int SW = $clog2(XLEN);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV} state_e;

  state_e                 state_q, state_d;
  logic [SW-1:0]          cnt_q, cnt_d;
  logic [2*XLEN-1:0]      acc_q, acc_d;
  logic [XLEN-1:0]        mcand_q, mcand_d;
  logic                   sel_q, sel_d, negq_q, negq_d, negr_q, negr_d;
  logic                   pwe_q, pwe_d;
  logic [RADDR_WIDTH-1:0] pwaddr_q, pwaddr_d;
  logic                   valid_q, valid_d, we_q, we_d;
  logic [RADDR_WIDTH-1:0] waddr_q, waddr_d;
  logic [XLEN-1:0]        wdata_q, wdata_d;

  logic [6:0]      opcode, funct7;
  logic [2:0]      funct3;
  logic [SW-1:0]   shamt;
  logic            is_imm, is_op, is_m, alu_ok, accept;
  logic            slt, sltu;
  logic [XLEN-1:0] sra_res, alu_res;
  logic            m_div, m_s1, m_s2, neg1, neg2, div0, ovf;
  logic [XLEN-1:0] mag1, mag2, spec_res;
  logic [XLEN:0]   mul_sum, div_diff;
  logic [2*XLEN-1:0] mul_nxt, div_nxt, prod_s;
  logic [XLEN-1:0] quo_s, rem_s, fin_res;
  logic            unused_inst;

  assign opcode      = inst_i[6:0];
  assign funct3      = inst_i[14:12];
  assign funct7      = inst_i[31:25];
  assign shamt       = op2_i[SW-1:0];
  assign unused_inst = ^{inst_i[24:15], inst_i[11:7]};
  assign is_imm      = (opcode == 7'b0010011);
  assign is_op       = (opcode == 7'b0110011);
  assign is_m        = (MULDIV_EN != 0) && is_op && (funct7 == 7'b0000001);
  assign accept      = valid_i && !flush_i && (state_q == S_IDLE);

  assign slt     = $signed(op1_i) < $signed(op2_i);
  assign sltu    = op1_i < op2_i;
  assign sra_res = $signed(op1_i) >>> shamt;

  always_comb begin
    alu_res = '0;
    unique case (funct3)
      3'b000:  alu_res = (is_op && inst_i[30]) ? op1_i - op2_i : op1_i + op2_i;
      3'b001:  alu_res = op1_i << shamt;
      3'b010:  alu_res = XLEN'(slt);
      3'b011:  alu_res = XLEN'(sltu);
      3'b100:  alu_res = op1_i ^ op2_i;
      3'b101:  alu_res = inst_i[30] ? sra_res : op1_i >> shamt;
      3'b110:  alu_res = op1_i | op2_i;
      default: alu_res = op1_i & op2_i;
    endcase
  end

  always_comb begin
    alu_ok = 1'b0;
    if (is_imm) begin
      unique case (funct3)
        3'b001:  alu_ok = (funct7 == 7'b0000000);
        3'b101:  alu_ok = (funct7 == 7'b0000000) || (funct7 == 7'b0100000);
        default: alu_ok = 1'b1;
      endcase
    end else if (is_op) begin
      if (funct7 == 7'b0000000)
        alu_ok = 1'b1;
      else if (funct7 == 7'b0100000)
        alu_ok = (funct3 == 3'b000) || (funct3 == 3'b101);
    end
  end

  // Operand signedness per funct3: MUL/MULH both signed, MULHSU op1 only, DIV/REM both.
  assign m_div    = funct3[2];
  assign m_s1     = funct3[2] ? !funct3[0] : (funct3[1:0] != 2'b11);
  assign m_s2     = funct3[2] ? !funct3[0] : !funct3[1];
  assign neg1     = m_s1 && op1_i[XLEN-1];
  assign neg2     = m_s2 && op2_i[XLEN-1];
  assign mag1     = neg1 ? -op1_i : op1_i;
  assign mag2     = neg2 ? -op2_i : op2_i;
  assign div0     = (op2_i == '0);
  assign ovf      = m_s1 && (op1_i == {1'b1, {(XLEN-1){1'b0}}}) && (op2_i == '1);
  assign spec_res = div0 ? (funct3[1] ? op1_i : '1) : (funct3[1] ? '0 : op1_i);

  // acc holds {partial product, remaining multiplier} or {partial remainder, dividend/quotient}.
  assign mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + {1'b0, (acc_q[0] ? mcand_q : '0)};
  assign mul_nxt  = {mul_sum, acc_q[XLEN-1:1]};
  assign div_diff = acc_q[2*XLEN-1:XLEN-1] - {1'b0, mcand_q};
  assign div_nxt  = div_diff[XLEN] ? {acc_q[2*XLEN-2:0], 1'b0}
                                   : {div_diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
  assign prod_s   = negq_q ? -mul_nxt : mul_nxt;
  assign quo_s    = negq_q ? -div_nxt[XLEN-1:0] : div_nxt[XLEN-1:0];
  assign rem_s    = negr_q ? -div_nxt[2*XLEN-1:XLEN] : div_nxt[2*XLEN-1:XLEN];
  assign fin_res  = (state_q == S_MUL) ? (sel_q ? prod_s[2*XLEN-1:XLEN] : prod_s[XLEN-1:0])
                                       : (sel_q ? rem_s : quo_s);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    sel_d    = sel_q;
    negq_d   = negq_q;
    negr_d   = negr_q;
    pwe_d    = pwe_q;
    pwaddr_d = pwaddr_q;
    valid_d  = 1'b0;
    we_d     = 1'b0;
    waddr_d  = waddr_q;
    wdata_d  = wdata_q;
    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (is_m && !(m_div && (div0 || ovf))) begin
            state_d  = m_div ? S_DIV : S_MUL;
            cnt_d    = '0;
            acc_d    = {{XLEN{1'b0}}, (m_div ? mag1 : mag2)};
            mcand_d  = m_div ? mag2 : mag1;
            sel_d    = m_div ? funct3[1] : (funct3[1:0] != 2'b00);
            negq_d   = neg1 ^ neg2;
            negr_d   = neg1;
            pwe_d    = reg_we_i;
            pwaddr_d = reg_waddr_i;
          end else begin
            valid_d = 1'b1;
            if (is_m || alu_ok) begin
              we_d    = reg_we_i;
              waddr_d = reg_waddr_i;
              wdata_d = is_m ? spec_res : alu_res;
            end else begin
              waddr_d = '0;
              wdata_d = '0;
            end
          end
        end
      end
      default: begin
        acc_d = (state_q == S_MUL) ? mul_nxt : div_nxt;
        cnt_d = cnt_q + SW'(1);
        if (cnt_q == SW'(XLEN-1)) begin
          state_d = S_IDLE;
          cnt_d   = '0;
          valid_d = 1'b1;
          we_d    = pwe_q;
          waddr_d = pwaddr_q;
          wdata_d = fin_res;
        end
      end
    endcase
    if (flush_i) begin
      state_d = S_IDLE;
      cnt_d   = '0;
      valid_d = 1'b0;
      we_d    = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      mcand_q  <= '0;
      sel_q    <= 1'b0;
      negq_q   <= 1'b0;
      negr_q   <= 1'b0;
      pwe_q    <= 1'b0;
      pwaddr_q <= '0;
      valid_q  <= 1'b0;
      we_q     <= 1'b0;
      waddr_q  <= '0;
      wdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      sel_q    <= sel_d;
      negq_q   <= negq_d;
      negr_q   <= negr_d;
      pwe_q    <= pwe_d;
      pwaddr_q <= pwaddr_d;
      valid_q  <= valid_d;
      we_q     <= we_d;
      waddr_q  <= waddr_d;
      wdata_q  <= wdata_d;
    end
  end

  assign ready_o     = (state_q == S_IDLE);
  assign valid_o     = valid_q;
  assign reg_we_o    = we_q;
  assign reg_waddr_o = waddr_q;
  assign reg_wdata_o = wdata_q;
endmodule

// File: tb/tb_exe_muldiv.sv
// Bench for exe_muldiv: vector table through a result scoreboard with latency
// checks, plus busy/flush/reset sequences and a MULDIV_EN=0 instance.
`timescale 1ns/1ps
module tb_exe_muldiv;
  localparam int XLEN = 32;
  localparam int RW   = 5;
  localparam logic [6:0] OPI = 7'b0010011;
  localparam logic [6:0] OPR = 7'b0110011;
  localparam logic [6:0] F0  = 7'b0000000;
  localparam logic [6:0] F1  = 7'b0100000;
  localparam logic [6:0] FM  = 7'b0000001;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic valid_i = 1'b0, flush_i = 1'b0, we_i = 1'b0;
  logic [31:0] inst = '0, op1 = '0, op2 = '0;
  logic [RW-1:0] waddr_i = '0;
  logic ready_o, valid_o, we_o, ready0, valid0, we0;
  logic [RW-1:0] waddr_o, waddr0;
  logic [XLEN-1:0] wdata_o, wdata0;

  always #5 clk = ~clk;

  exe_muldiv #(.XLEN(XLEN), .RADDR_WIDTH(RW), .MULDIV_EN(1)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .valid_i(valid_i), .ready_o(ready_o), .flush_i(flush_i),
    .inst_i(inst), .op1_i(op1), .op2_i(op2), .reg_we_i(we_i), .reg_waddr_i(waddr_i),
    .valid_o(valid_o), .reg_we_o(we_o), .reg_waddr_o(waddr_o), .reg_wdata_o(wdata_o));

  exe_muldiv #(.XLEN(XLEN), .RADDR_WIDTH(RW), .MULDIV_EN(0)) dut0 (
    .clk_i(clk), .rst_n_i(rst_n), .valid_i(valid_i), .ready_o(ready0), .flush_i(flush_i),
    .inst_i(inst), .op1_i(op1), .op2_i(op2), .reg_we_i(we_i), .reg_waddr_i(waddr_i),
    .valid_o(valid0), .reg_we_o(we0), .reg_waddr_o(waddr0), .reg_wdata_o(wdata0));

  typedef struct {
    logic          we;
    logic [RW-1:0] waddr;
    logic [31:0]   data;
    int            lat;
    int            t;
    int            tag;
  } exp_t;

  typedef struct {
    logic [31:0] inst;
    logic [31:0] a;
    logic [31:0] b;
    logic        we;
    logic [31:0] exp;
    logic        ok;
    int          lat;
  } vec_t;

  exp_t sb[$];
  vec_t vt[$];
  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;

  always @(posedge clk) cyc++;

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] req);
    n_cmp++;
    if (got !== req) begin
      n_bad++;
      $display("FAIL %s: got %h required %h", nm, got, req);
    end
  endtask

  function automatic logic [31:0] enc(input logic [6:0] f7, input logic [2:0] f3,
                                      input logic [6:0] opc);
    enc = {f7, 5'd2, 5'd1, f3, 5'd3, opc};
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (valid_o) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_valid: got valid_o=1 data=%h, required no result", wdata_o);
      end else begin
        e = sb.pop_front();
        chk($sformatf("result#%0d", e.tag), {26'd0, we_o, waddr_o, wdata_o},
            {26'd0, e.we, e.waddr, e.data});
        chk($sformatf("latency#%0d", e.tag), 64'(cyc - e.t), 64'(e.lat));
      end
    end else if (rst_n) begin
      chk("we_without_valid", {63'd0, we_o}, 64'd0);
    end
  end

  task automatic issue(input logic [31:0] ins, input logic [31:0] a, input logic [31:0] b,
                       input logic we, input logic [RW-1:0] wa, input logic push,
                       input logic [31:0] ed, input logic ok, input int lat, input int tag);
    int w = 0;
    while (!ready_o && w < 100) begin
      valid_i = 1'b0;
      @(negedge clk);
      w++;
    end
    if (!ready_o) begin
      n_cmp++;
      n_bad++;
      $display("FAIL ready_timeout#%0d: ready_o=0, required 1 within 100 cycles", tag);
    end
    valid_i = 1'b1;
    inst = ins; op1 = a; op2 = b; we_i = we; waddr_i = wa;
    if (push)
      sb.push_back('{we: ok & we, waddr: ok ? wa : '0, data: ok ? ed : '0,
                     lat: lat, t: cyc, tag: tag});
    @(negedge clk);
    valid_i = 1'b0;
  endtask

  task automatic drain();
    int w = 0;
    while (sb.size() != 0 && w < 200) begin
      @(negedge clk);
      w++;
    end
    if (sb.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain: %0d results outstanding, required 0", sb.size());
      sb.delete();
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation still running, required self-termination");
    $fatal(1);
  end

  initial begin
    int lows;
    vt.push_back('{enc(F0, 3'b110, OPI), 32'h0000_00F0, 32'h0000_000F, 1'b1, 32'h0000_00FF, 1'b1, 1});
    vt.push_back('{enc(F1, 3'b000, OPR), 32'd5, 32'd7, 1'b1, 32'hFFFF_FFFE, 1'b1, 1});
    vt.push_back('{enc(F1, 3'b101, OPR), 32'h8000_0000, 32'd4, 1'b1, 32'hF800_0000, 1'b1, 1});
    vt.push_back('{enc(F0, 3'b011, OPR), 32'd1, 32'hFFFF_FFFF, 1'b1, 32'd1, 1'b1, 1});
    vt.push_back('{enc(F0, 3'b000, OPI), 32'h7FFF_FFFF, 32'd1, 1'b1, 32'h8000_0000, 1'b1, 1});
    vt.push_back('{enc(F0, 3'b010, OPI), 32'hFFFF_FFFF, 32'd1, 1'b1, 32'd1, 1'b1, 1});
    vt.push_back('{enc(F0, 3'b011, OPI), 32'hFFFF_FFFF, 32'd1, 1'b1, 32'd0, 1'b1, 1});
    vt.push_back('{enc(F0, 3'b100, OPI), 32'hAAAA_5555, 32'hFFFF_FFFF, 1'b1, 32'h5555_AAAA, 1'b1, 1});
    vt.push_back('{enc(F0, 3'b111, OPI), 32'h1234_5678, 32'h0000_00FF, 1'b1, 32'h0000_0078, 1'b1, 1});
    vt.push_back('{enc(F0, 3'b001, OPI), 32'd1, 32'h0000_0023, 1'b1, 32'd8, 1'b1, 1});
    vt.push_back('{enc(F0, 3'b101, OPI), 32'h8000_0000, 32'h1F, 1'b1, 32'd1, 1'b1, 1});
    vt.push_back('{enc(F1, 3'b101, OPI), 32'h8000_0000, 32'h1F, 1'b1, 32'hFFFF_FFFF, 1'b1, 1});
    vt.push_back('{enc(F0, 3'b001, OPR), 32'd3, 32'd4, 1'b1, 32'h30, 1'b1, 1});
    vt.push_back('{enc(F0, 3'b010, OPR), 32'h8000_0000, 32'd0, 1'b1, 32'd1, 1'b1, 1});
    vt.push_back('{enc(F0, 3'b000, OPR), 32'hFFFF_FFFF, 32'd1, 1'b0, 32'd0, 1'b1, 1});
    vt.push_back('{enc(F0, 3'b110, OPR), 32'hF0F0_0000, 32'h0000_F0F0, 1'b1, 32'hF0F0_F0F0, 1'b1, 1});
    vt.push_back('{enc(F0, 3'b100, OPR), 32'hFF00_FF00, 32'h0FF0_0FF0, 1'b1, 32'hF0F0_F0F0, 1'b1, 1});
    vt.push_back('{enc(F0, 3'b111, OPR), 32'hFF00_FF00, 32'h0FF0_0FF0, 1'b1, 32'h0F00_0F00, 1'b1, 1});
    vt.push_back('{enc(F0, 3'b101, OPR), 32'h8000_0000, 32'h21, 1'b1, 32'h4000_0000, 1'b1, 1});
    vt.push_back('{enc(F0, 3'b010, 7'b0000011), 32'h1111_1111, 32'd4, 1'b1, 32'd0, 1'b0, 1});
    vt.push_back('{enc(7'b0000010, 3'b000, OPR), 32'd1, 32'd2, 1'b1, 32'd0, 1'b0, 1});
    vt.push_back('{enc(FM, 3'b001, OPR), 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'h0, 1'b1, 33});
    vt.push_back('{enc(FM, 3'b011, OPR), 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFE, 1'b1, 33});
    vt.push_back('{enc(FM, 3'b000, OPR), 32'd7, 32'hFFFF_FFFD, 1'b1, 32'hFFFF_FFEB, 1'b1, 33});
    vt.push_back('{enc(FM, 3'b010, OPR), 32'hFFFF_FFFF, 32'd2, 1'b1, 32'hFFFF_FFFF, 1'b1, 33});
    vt.push_back('{enc(FM, 3'b011, OPR), 32'h0001_0000, 32'h0001_0000, 1'b1, 32'd1, 1'b1, 33});
    vt.push_back('{enc(FM, 3'b000, OPR), 32'h8000_0000, 32'h8000_0000, 1'b1, 32'd0, 1'b1, 33});
    vt.push_back('{enc(FM, 3'b001, OPR), 32'h8000_0000, 32'h8000_0000, 1'b1, 32'h4000_0000, 1'b1, 33});
    vt.push_back('{enc(FM, 3'b100, OPR), 32'hFFFF_FFF9, 32'd2, 1'b1, 32'hFFFF_FFFD, 1'b1, 33});
    vt.push_back('{enc(FM, 3'b110, OPR), 32'hFFFF_FFF9, 32'd2, 1'b1, 32'hFFFF_FFFF, 1'b1, 33});
    vt.push_back('{enc(FM, 3'b101, OPR), 32'd7, 32'd0, 1'b1, 32'hFFFF_FFFF, 1'b1, 1});
    vt.push_back('{enc(FM, 3'b111, OPR), 32'd7, 32'd0, 1'b1, 32'd7, 1'b1, 1});
    vt.push_back('{enc(FM, 3'b100, OPR), 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'h8000_0000, 1'b1, 1});
    vt.push_back('{enc(FM, 3'b110, OPR), 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'd0, 1'b1, 1});
    vt.push_back('{enc(FM, 3'b100, OPR), 32'd5, 32'd0, 1'b1, 32'hFFFF_FFFF, 1'b1, 1});
    vt.push_back('{enc(FM, 3'b110, OPR), 32'hFFFF_FFF9, 32'd0, 1'b1, 32'hFFFF_FFF9, 1'b1, 1});
    vt.push_back('{enc(FM, 3'b101, OPR), 32'd100, 32'd7, 1'b1, 32'd14, 1'b1, 33});
    vt.push_back('{enc(FM, 3'b111, OPR), 32'd100, 32'd7, 1'b1, 32'd2, 1'b1, 33});
    vt.push_back('{enc(FM, 3'b100, OPR), 32'd7, 32'hFFFF_FFFE, 1'b1, 32'hFFFF_FFFD, 1'b1, 33});
    vt.push_back('{enc(FM, 3'b110, OPR), 32'd7, 32'hFFFF_FFFE, 1'b1, 32'd1, 1'b1, 33});
    vt.push_back('{enc(FM, 3'b100, OPR), 32'h8000_0000, 32'd2, 1'b1, 32'hC000_0000, 1'b1, 33});
    vt.push_back('{enc(FM, 3'b101, OPR), 32'hFFFF_FFFF, 32'd1, 1'b1, 32'hFFFF_FFFF, 1'b1, 33});

    // Reset state, with an instruction offered while reset is held.
    valid_i = 1'b1; inst = enc(F0, 3'b000, OPI); op1 = 32'd1; op2 = 32'd1; we_i = 1'b1; waddr_i = 5'd7;
    repeat (2) @(negedge clk);
    chk("reset_state", {57'd0, valid_o, ready_o, we_o, waddr_o, wdata_o[0]}, {57'd0, 1'b0, 1'b1, 1'b0, 5'd0, 1'b0});
    chk("reset_wdata", {32'd0, wdata_o}, 64'd0);
    valid_i = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);

    // MULDIV_EN=0 instance: M op and unknown opcode give a blank result after one cycle.
    issue(enc(F0, 3'b110, OPI), 32'h0000_00F0, 32'h0000_000F, 1'b1, 5'd1, 1'b1, 32'hFF, 1'b1, 1, 100);
    issue(enc(FM, 3'b000, OPR), 32'd6, 32'd7, 1'b1, 5'd3, 1'b1, 32'd42, 1'b1, 33, 101);
    chk("nomd_mul", {26'd0, valid0, we0, waddr0, wdata0}, {26'd0, 1'b1, 1'b0, 5'd0, 32'd0});
    @(negedge clk);
    chk("nomd_pulse", {63'd0, valid0}, 64'd0);
    issue(enc(F0, 3'b110, OPI), 32'h0000_00F0, 32'h0000_000F, 1'b1, 5'd1, 1'b1, 32'hFF, 1'b1, 1, 102);
    issue(enc(F0, 3'b010, 7'b0000011), 32'h10, 32'd4, 1'b1, 5'd5, 1'b1, 32'd0, 1'b0, 1, 103);
    chk("nomd_load", {26'd0, valid0, we0, waddr0, wdata0}, {26'd0, 1'b1, 1'b0, 5'd0, 32'd0});

    foreach (vt[i])
      issue(vt[i].inst, vt[i].a, vt[i].b, vt[i].we, RW'(i % 31 + 1), 1'b1,
            vt[i].exp, vt[i].ok, vt[i].lat, i);
    drain();

    // ready_o must stay low for exactly XLEN cycles of a multiply.
    issue(enc(FM, 3'b011, OPR), 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 5'd9, 1'b1, 32'hFFFF_FFFE, 1'b1, 33, 200);
    lows = 0;
    for (int k = 0; k < 32; k++) begin
      if (!ready_o) lows++;
      @(negedge clk);
    end
    chk("busy_ready_lows", 64'(lows), 64'd32);
    chk("busy_ready_release", {63'd0, ready_o}, 64'd1);
    drain();

    // Flush mid-divide, then flush in IDLE with an instruction offered.
    issue(enc(FM, 3'b101, OPR), 32'd100, 32'd7, 1'b1, 5'd4, 1'b0, 32'd0, 1'b1, 33, 300);
    repeat (8) @(negedge clk);
    flush_i = 1'b1;
    @(negedge clk);
    flush_i = 1'b0;
    chk("flush_busy_valid", {63'd0, valid_o}, 64'd0);
    chk("flush_ready", {63'd0, ready_o}, 64'd1);
    flush_i = 1'b1; valid_i = 1'b1;
    inst = enc(F0, 3'b000, OPI); op1 = 32'd1; op2 = 32'd2; we_i = 1'b1; waddr_i = 5'd6;
    @(negedge clk);
    flush_i = 1'b0; valid_i = 1'b0;
    chk("flush_idle_valid", {63'd0, valid_o}, 64'd0);
    repeat (40) @(negedge clk);

    // Asynchronous reset in the middle of a multiply.
    issue(enc(FM, 3'b000, OPR), 32'd3, 32'd5, 1'b1, 5'd8, 1'b0, 32'd0, 1'b1, 33, 400);
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midreset_outputs", {26'd0, valid_o, we_o, waddr_o, wdata_o}, 64'd0);
    chk("midreset_ready", {63'd0, ready_o}, 64'd1);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    chk("post_reset_ready", {63'd0, ready_o}, 64'd1);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/exe_muldiv.md
# exe_muldiv

Parametrised execute stage for the RISC-V core, sitting between `id_exe` and `exe_mem`. It executes all OP-IMM and OP integer instructions in one cycle and, when enabled, the M-extension multiply/divide instructions through an iterative multi-cycle unit. Results are registered and presented to `exe_mem` with a valid/ready-style input handshake, so the pipeline stalls while a multiply or divide is in flight.

## Interface
- `XLEN`, 32: data width; even, ≥ 8.
- `RADDR_WIDTH`, 5: register address width.
- `MULDIV_EN`, 1: 1 = M-extension executed; 0 = M encodings treated as unsupported.

- `clk_i`  in  1  clock; all state on rising edge.
- `rst_n_i`  in  1  reset; one clock; asynchronous, active-low.
- `valid_i`  in  1  `id_exe` presents an instruction.
- `ready_o`  out  1  stage can accept; = (state == IDLE).
- `flush_i`  in  1  abort in-flight and incoming instruction.
- `inst_i`  in  32  instruction word.
- `op1_i`  in  XLEN  rs1 value.
- `op2_i`  in  XLEN  rs2 value (OP) or sign-extended immediate (OP-IMM).
- `reg_we_i`  in  1  write enable from decode.
- `reg_waddr_i`  in  RADDR_WIDTH  destination register.
- `valid_o`  out  1  result valid, one-cycle pulse per instruction.
- `reg_we_o`  out  1  write enable to `exe_mem`.
- `reg_waddr_o`  out  RADDR_WIDTH  destination register.
- `reg_wdata_o`  out  XLEN  result.

## Operation
- Accept = `valid_i && ready_o && !flush_i`. Decode uses opcode `inst_i[6:0]`, funct3 `[14:12]`, funct7 `[31:25]`.
- OP-IMM (0010011): ADDI, SLTI, SLTIU, XORI, ORI, ANDI, SLLI, SRLI, SRAI. Shift amount = `op2_i[$clog2(XLEN)-1:0]`; SRA vs SRL selected by `inst_i[30]`.
- OP (0110011), funct7 0000000/0100000: ADD/SUB (`inst_i[30]`), SLL, SLT, SLTU, XOR, SRL/SRA, OR, AND. All arithmetic modulo 2^XLEN.
- OP, funct7 0000001 with `MULDIV_EN`=1: MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU.
- Multiplier: magnitudes of signed operands latched; shift-add, one bit per cycle, XLEN iterations, 2·XLEN product; negate if sign of result negative. MUL returns low XLEN bits; MULH/MULHSU/MULHU the high XLEN bits. MULHSU: op1 signed, op2 unsigned.
- Divider: restoring, one quotient bit per cycle, XLEN iterations on magnitudes; quotient sign = sign(op1) XOR sign(op2); remainder sign = sign(op1).
- Special cases, resolved at accept without iterating: divisor 0 → quotient all ones, remainder = op1; signed DIV/REM with op1 = −2^(XLEN−1) and op2 = −1 → quotient = op1, remainder 0.
- Unsupported opcode/funct (including M with `MULDIV_EN`=0): `valid_o` still pulses; `reg_we_o`=0, `reg_waddr_o`=0, `reg_wdata_o`=0.
- Supported instructions pass `reg_we_i`/`reg_waddr_i` through unchanged, captured at accept.
- FSM: IDLE → MUL or DIV on accept of a non-special M op; MUL/DIV count XLEN cycles, on last count load result registers, return to IDLE. ALU, special-case and unsupported ops stay in IDLE.
- `flush_i` in any state: return to IDLE, counter cleared, pending result discarded; instruction offered the same cycle is not accepted; `valid_o` is 0 the next cycle.

## Timing
- Reset (async, `rst_n_i`=0): state IDLE, counter 0, `valid_o`=0, `reg_we_o`=0, `reg_waddr_o`=0, `reg_wdata_o`=0; `ready_o`=1 but inputs ignored until `rst_n_i` deasserts. Reset mid-multiply/divide discards it; no `valid_o`.
- ALU, special-case, unsupported: accept at edge T → `valid_o`=1 with result in cycle T+1. Back-to-back accepts every cycle, one result per cycle.
- MUL/DIV: accept at T → `ready_o`=0 for cycles T+1..T+XLEN; `valid_o`=1 with result in cycle T+XLEN+1, `ready_o`=1 that same cycle, allowing a new accept on that edge.
- `valid_o` is a single-cycle pulse; outputs hold previous values while `valid_o`=0 (don't-care for `exe_mem`, but `reg_we_o` forced 0).
- No downstream backpressure: `exe_mem` always consumes `valid_o`.

## Test plan
- Reset then ORI x1, op1=0x0000_00F0, op2=0x0000_000F, waddr=1 → next cycle `valid_o`=1, `reg_wdata_o`=0x0000_00FF, `reg_waddr_o`=1, `reg_we_o`=1.
- Back-to-back SUB (5−7), SRA (0x8000_0000 >> 4), SLTU (1 < 0xFFFF_FFFF) → three consecutive `valid_o` pulses with 0xFFFF_FFFE, 0xF800_0000, 1.
- MULH op1=0xFFFF_FFFF, op2=0xFFFF_FFFF; MULHU same operands → 0x0000_0000 and 0xFFFF_FFFE, each exactly 33 cycles after accept; `ready_o`=0 for the 32 cycles between.
- DIV −7/2 → −3 (0xFFFF_FFFD); REM −7/2 → 0xFFFF_FFFF; DIVU 7/0 → 0xFFFF_FFFF after 1 cycle; DIV 0x8000_0000/−1 → 0x8000_0000, REM → 0, both after 1 cycle.
- Start DIVU, assert `flush_i` at cycle 10, then `rst_n_i` low mid-MUL → no `valid_o` either time; `ready_o`=1 the cycle after flush; outputs 0 during reset.
- `MULDIV_EN`=0 build, MUL x3 and opcode 0000011 → `valid_o`=1, `reg_we_o`=0, `reg_waddr_o`=0, `reg_wdata_o`=0, 1-cycle latency.
